uart_frame_sender: RTL

//  Parametrised successor of the single-byte UART send FSM. Queues multi-byte words in a FIFO and frames

---
 rtl/uart_frame_sender_pkg.sv | 27 ++
 rtl/uart_frame_sender_fifo.sv | 62 ++++++
 rtl/uart_frame_sender.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_frame_sender_pkg.sv
// Shared types and constants for the UART frame sender.
// Optional feature macro: UART_FRAME_CHECKSUM_EN (appends an XOR checksum byte to every frame).
package uart_frame_sender_pkg;

    // Frame sender FSM states (3-bit encoding)
    typedef enum logic [2:0] {
        UFS_IDLE  = 3'd0,
        UFS_LOAD  = 3'd1,
        UFS_START = 3'd2,
        UFS_ACK   = 3'd3,
        UFS_DONE  = 3'd4,
        UFS_NEXT  = 3'd5
    } ufs_state_t;

    // Default sync byte sent ahead of each payload
    localparam logic [7:0] UFS_DEFAULT_HEADER = 8'hA5;

    // Total bytes on the wire per frame: header + payload (+ checksum when enabled)
    function automatic int unsigned ufs_frame_len(input int unsigned num_bytes);
`ifdef UART_FRAME_CHECKSUM_EN
        return num_bytes + 2;
`else
        return num_bytes + 1;
`endif
    endfunction

endpackage

// File: rtl/uart_frame_sender_fifo.sv
// Synchronous word FIFO feeding the frame sender. Power-of-two depth, so the
// pointers wrap naturally; count tracks occupancy and is guarded by full/empty.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_frame_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage array: written on accepted pushes only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_sender.sv
// Queues multi-byte words and frames each as HEADER + payload (LS byte first),
// driving a uart_transmit start/ready handshake one byte at a time.
// Optional feature macro: UART_FRAME_CHECKSUM_EN -- appends XOR(header, payload) byte.
module uart_frame_sender
    import uart_frame_sender_pkg::*;
#(
    parameter int unsigned NUM_BYTES   = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [7:0]  HEADER_BYTE = UFS_DEFAULT_HEADER,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [8*NUM_BYTES-1:0]          word_i,
    input  logic                            word_valid_i,
    output logic                            word_ready_o,
    output logic                            tx_send_o,
    output logic [7:0]                      tx_data_o,
    input  logic                            tx_ready_i,
    output logic                            busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
    output logic                            overflow_o,
    output logic                            timeout_o
);

    localparam int unsigned WORD_W    = 8 * NUM_BYTES;
    localparam int unsigned IDX_W     = $clog2(NUM_BYTES + 2);
    localparam int unsigned TMR_W     = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned FRAME_LEN = ufs_frame_len(NUM_BYTES);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(ACK_TIMEOUT);

    ufs_state_t        state;
    logic [WORD_W-1:0] shift_q;
    logic [IDX_W-1:0]  byte_idx;
    logic [TMR_W-1:0]  timer;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_head;

    // A word leaves the FIFO on the IDLE->LOAD transition
    assign fifo_pop = (state == UFS_IDLE) & ~fifo_empty & tx_ready_i;

    // Ready also covers the full-and-draining cycle so that push and pop can
    // coincide at full occupancy without losing the offered word.
    assign word_ready_o = ~fifo_full | fifo_pop;
    assign busy_o       = (state != UFS_IDLE) | ~fifo_empty;

    uart_frame_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (word_valid_i),
        .push_data (word_i),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_o)
    );

    // Sticky flag for words offered while the FIFO could not take them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (word_valid_i & fifo_full & ~fifo_pop) begin
            overflow_o <= 1'b1;
        end
    end

    // Frame sequencing FSM with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= UFS_IDLE;
            shift_q   <= '0;
            byte_idx  <= '0;
            timer     <= '0;
            tx_send_o <= 1'b0;
            tx_data_o <= '0;
            timeout_o <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            timeout_o <= 1'b0;
            case (state)
                UFS_IDLE: begin
                    if (fifo_pop) begin
                        shift_q  <= fifo_head;
                        byte_idx <= '0;
                        state    <= UFS_LOAD;
                    end
                end
                // tx_send_o is raised on entry to START so it is high for
                // exactly the START cycle.
                UFS_LOAD: begin
                    tx_data_o <= HEADER_BYTE;
`ifdef UART_FRAME_CHECKSUM_EN
                    csum_q    <= HEADER_BYTE;
`endif
                    tx_send_o <= 1'b1;
                    state     <= UFS_START;
                end
                UFS_START: begin
                    tx_send_o <= 1'b0;
                    timer     <= '0;
                    state     <= UFS_ACK;
                end
                UFS_ACK: begin
                    if (!tx_ready_i) begin
                        state <= UFS_DONE;
                    end else if (timer == TMR_LIMIT) begin
                        timeout_o <= 1'b1;
                        tx_send_o <= 1'b1;
                        state     <= UFS_START;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                UFS_DONE: begin
                    if (tx_ready_i) begin
                        state <= UFS_NEXT;
                    end
                end
                // byte_idx names the byte currently in tx_data_o; payload is
                // taken from the bottom of the shift register, LS byte first.
                UFS_NEXT: begin
                    if (byte_idx == LAST_IDX) begin
                        state <= UFS_IDLE;
                    end else begin
                        byte_idx  <= byte_idx + 1'b1;
                        tx_send_o <= 1'b1;
                        state     <= UFS_START;
`ifdef UART_FRAME_CHECKSUM_EN
                        if (byte_idx == IDX_W'(NUM_BYTES)) begin
                            tx_data_o <= csum_q;
                        end else begin
                            tx_data_o <= shift_q[7:0];
                            shift_q   <= shift_q >> 8;
                            csum_q    <= csum_q ^ shift_q[7:0];
                        end
`else
                        tx_data_o <= shift_q[7:0];
                        shift_q   <= shift_q >> 8;
`endif
                    end
                end
                default: begin
                    tx_send_o <= 1'b0;
                    state     <= UFS_IDLE;
                end
            endcase
        end
    end

endmodule
